// File: rtl/memory_stage_if.sv
// Data-memory port of the memory stage: request (valid/ready) and single-beat response.
// master = memory stage side, slave = memory side.
interface memory_stage_if #(
  parameter int XLEN = 32
);
  logic              dreq_valid;
  logic              dreq_ready;
  logic [XLEN-1:0]   dreq_addr;
  logic              dreq_wen;
  logic [XLEN-1:0]   dreq_wdata;
  logic [XLEN/8-1:0] dreq_wmask;
  logic              dresp_valid;
  logic [XLEN-1:0]   dresp_rdata;

  modport master (
    output dreq_valid, dreq_addr, dreq_wen, dreq_wdata, dreq_wmask,
    input  dreq_ready, dresp_valid, dresp_rdata
  );

  modport slave (
    input  dreq_valid, dreq_addr, dreq_wen, dreq_wdata, dreq_wmask,
    output dreq_ready, dresp_valid, dresp_rdata
  );
endinterface

// File: rtl/memory_stage.sv
// memory_stage: performs LB/LH/LW/LBU/LHU/SB/SH/SW on a valid/ready data-memory port.
// Optional MEMSTAGE_MISALIGN_TRAP_EN: misaligned half/word accesses are flagged, not issued.
module memory_stage #(
  parameter int XLEN      = 32,
  parameter int IID_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 valid,
  input  logic                 is_new,
  input  logic [IID_WIDTH-1:0] inst_id,
  input  logic [1:0]           mem_sel,
  input  logic [1:0]           mem_size,
  input  logic                 mem_signed,
  input  logic [XLEN-1:0]      alu_out,
  input  logic [XLEN-1:0]      rs2_data,
  memory_stage_if.master       dmem,
  output logic [XLEN-1:0]      next_mem_out,
  output logic                 is_stall,
  output logic                 misalign
);

  typedef enum logic [1:0] {IDLE, WAIT_READY, WAIT_RESP, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   saved_data_q, saved_data_d;
  logic              pending_q, pending_d;

  logic              is_load, is_store, is_mem, is_acc;
  logic              size_half, size_word;
  logic              misaligned;
  logic [1:0]        offset;
  logic              issue;
  logic              req_valid;
  logic [XLEN-1:0]   lane;
  logic [XLEN-1:0]   load_fmt;
  logic [XLEN-1:0]   store_rep;
  logic [XLEN/8-1:0] mask_base;
  logic              unused_iid;

  assign unused_iid = ^inst_id;

  assign is_load   = (mem_sel == 2'd1);
  assign is_store  = (mem_sel == 2'd2);
  assign is_mem    = is_load | is_store;
  assign size_half = (mem_size == 2'd1);
  assign size_word = mem_size[1];

`ifdef MEMSTAGE_MISALIGN_TRAP_EN
  assign misaligned = is_mem & ((size_half & alu_out[0]) | (size_word & (|alu_out[1:0])));
  assign offset     = alu_out[1:0];
`else
  // Without the trap, the low address bits are simply forced to the access alignment.
  assign misaligned = 1'b0;
  assign offset     = size_word ? 2'b00 : (size_half ? {alu_out[1], 1'b0} : alu_out[1:0]);
`endif

  assign is_acc   = is_mem & ~misaligned;
  assign misalign = valid & misaligned;

  // pending_q remembers a new access that arrived during DRAIN, since is_new is single-cycle.
  assign issue = valid & is_acc & ~flush & (is_new | pending_q);

  always_comb begin
    lane     = dmem.dresp_rdata >> {offset, 3'b000};
    load_fmt = '0;
    if (is_load) begin
      if (size_word)
        load_fmt = lane;
      else if (size_half)
        load_fmt = {{(XLEN-16){mem_signed & lane[15]}}, lane[15:0]};
      else
        load_fmt = {{(XLEN-8){mem_signed & lane[7]}}, lane[7:0]};
    end
  end

  always_comb begin
    store_rep = rs2_data;
    mask_base = '1;
    if (size_half) begin
      store_rep = {(XLEN/16){rs2_data[15:0]}};
      mask_base = {{(XLEN/8-2){1'b0}}, 2'b11};
    end else if (!size_word) begin
      store_rep = {(XLEN/8){rs2_data[7:0]}};
      mask_base = {{(XLEN/8-1){1'b0}}, 1'b1};
    end
  end

  assign dmem.dreq_valid = req_valid;
  assign dmem.dreq_addr  = req_valid ? {alu_out[XLEN-1:2], 2'b00} : '0;
  assign dmem.dreq_wen   = req_valid & is_store;
  assign dmem.dreq_wdata = (req_valid & is_store) ? (store_rep << {offset, 3'b000}) : '0;
  assign dmem.dreq_wmask = req_valid ? (mask_base << offset) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      saved_data_q <= '0;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      saved_data_q <= saved_data_d;
      pending_q    <= pending_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    saved_data_d = saved_data_q;
    case (state_q)
      IDLE: begin
        if (issue)
          state_d = dmem.dreq_ready ? WAIT_RESP : WAIT_READY;
      end
      WAIT_READY: begin
        // A handshake that coincides with a flush still owes us a response.
        if (!valid)
          state_d = IDLE;
        else if (dmem.dreq_ready)
          state_d = flush ? DRAIN : WAIT_RESP;
        else if (flush)
          state_d = IDLE;
      end
      WAIT_RESP: begin
        if (dmem.dresp_valid) begin
          state_d = IDLE;
          if (!flush)
            saved_data_d = load_fmt;
        end else if (flush || !valid) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (dmem.dresp_valid)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pending_d = pending_q;
    if (flush || !valid)
      pending_d = 1'b0;
    else if (state_q == DRAIN && is_new && is_acc)
      pending_d = 1'b1;
    else if (state_q == IDLE && issue)
      pending_d = 1'b0;
  end

  always_comb begin
    req_valid    = 1'b0;
    is_stall     = 1'b0;
    next_mem_out = '0;
    case (state_q)
      IDLE: begin
        req_valid = issue;
        is_stall  = valid & is_acc & (is_new | pending_q);
      end
      WAIT_READY: begin
        req_valid = valid;
        is_stall  = valid;
      end
      WAIT_RESP: begin
        is_stall = valid & ~dmem.dresp_valid;
      end
      DRAIN: begin
        is_stall = valid & is_acc & (is_new | pending_q);
      end
      default: ;
    endcase

    if (valid) begin
      if (!is_acc)
        next_mem_out = alu_out;
      else if (state_q == WAIT_RESP && dmem.dresp_valid)
        next_mem_out = load_fmt;
      else if (state_q == IDLE && !is_new && !pending_q)
        next_mem_out = saved_data_q;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Testbench for memory_stage: table of load/store/passthrough vectors run against a
// reactive memory responder with a request/result scoreboard, plus flush and alignment sequences.
module tb_memory_stage;

  localparam int XLEN = 32;

  typedef struct {
    logic [1:0]  sel;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          rdy_dly;
    int          rsp_dly;
    logic [31:0] exp_out;
    logic [31:0] exp_addr;
    logic        exp_wen;
    logic [3:0]  exp_mask;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        valid = 1'b0;
  logic        is_new = 1'b0;
  logic [7:0]  inst_id = 8'h0;
  logic [1:0]  mem_sel = 2'd0;
  logic [1:0]  mem_size = 2'd0;
  logic        mem_signed = 1'b0;
  logic [31:0] alu_out = 32'h0;
  logic [31:0] rs2_data = 32'h0;
  logic [31:0] next_mem_out;
  logic        is_stall;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  req_t        req_q[$];
  logic [31:0] out_q[$];
  vec_t        vecs[13];

  memory_stage_if #(.XLEN(XLEN)) dmem();

  memory_stage #(.XLEN(XLEN), .IID_WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .valid       (valid),
    .is_new      (is_new),
    .inst_id     (inst_id),
    .mem_sel     (mem_sel),
    .mem_size    (mem_size),
    .mem_signed  (mem_signed),
    .alu_out     (alu_out),
    .rs2_data    (rs2_data),
    .dmem        (dmem),
    .next_mem_out(next_mem_out),
    .is_stall    (is_stall),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Runs one table vector: the responder raises ready after rdy_dly cycles and answers
  // rsp_dly cycles after the minimum one-cycle latency following the observed handshake.
  task automatic applyStimulus(input vec_t v, input int idx);
    int   c, hs, stalls, rsp_at, exp_stalls;
    bit   done, mem_op;
    req_t r;
    string tag;
    tag    = $sformatf("v%0d", idx);
    mem_op = (v.sel == 2'd1) || (v.sel == 2'd2);
    @(posedge clk); #1;
    valid = 1'b1; is_new = 1'b1; flush = 1'b0;
    mem_sel = v.sel; mem_size = v.size; mem_signed = v.sgn;
    alu_out = v.addr; rs2_data = v.rs2; inst_id = idx[7:0];
    if (mem_op) req_q.push_back('{v.exp_addr, v.exp_wen, v.exp_mask, v.exp_wdata});
    out_q.push_back(v.exp_out);
    c = 0; hs = 0; stalls = 0; rsp_at = -1; done = 1'b0;
    while (!done && c < 40) begin
      dmem.dreq_ready  = (c >= v.rdy_dly);
      dmem.dresp_valid = (rsp_at == c);
      dmem.dresp_rdata = (rsp_at == c) ? v.rdata : 32'h0BAD_0BAD;
      @(negedge clk);
      if (dmem.dreq_valid) begin
        if (req_q.size() > 0) begin
          r = req_q[0];
          checkOutput({tag, ".addr"},  dmem.dreq_addr,  r.addr);
          checkOutput({tag, ".wen"},   {31'h0, dmem.dreq_wen}, {31'h0, r.wen});
          checkOutput({tag, ".wmask"}, {28'h0, dmem.dreq_wmask}, {28'h0, r.mask});
          checkOutput({tag, ".wdata"}, dmem.dreq_wdata, r.wdata);
          if (dmem.dreq_ready) begin
            void'(req_q.pop_front());
            hs++;
            rsp_at = c + 1 + v.rsp_dly;
          end
        end else begin
          checkOutput({tag, ".spurious_req"}, 32'h1, 32'h0);
        end
      end
      if (!is_stall) begin
        checkOutput({tag, ".out"}, next_mem_out, out_q.pop_front());
        done = 1'b1;
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
      is_new = 1'b0;
      c++;
    end
    dmem.dreq_ready = 1'b0; dmem.dresp_valid = 1'b0;
    if (!done) begin
      checkOutput({tag, ".timeout"}, c, 32'h0);
      out_q.delete();
    end
    req_q.delete();
    exp_stalls = mem_op ? (v.rdy_dly + 1 + v.rsp_dly) : 0;
    checkOutput({tag, ".stall_cycles"}, stalls, exp_stalls);
    checkOutput({tag, ".handshakes"}, hs, mem_op ? 1 : 0);
    @(negedge clk);
    checkOutput({tag, ".held_out"}, next_mem_out, v.exp_out);
    checkOutput({tag, ".held_stall"}, {31'h0, is_stall}, 32'h0);
  endtask

  // Either flush the load in WAIT_RESP, or flush it while ready completes the handshake
  // in WAIT_READY; both must drain one response before the next load is issued.
  task automatic runFlushSeq(input bit via_ready, input logic [31:0] addr0, input logic [31:0] addr1);
    string tag;
    tag = via_ready ? "flush_rdy" : "flush_resp";
    @(posedge clk); #1;
    valid = 1'b1; is_new = 1'b1; flush = 1'b0;
    mem_sel = 2'd1; mem_size = 2'd2; mem_signed = 1'b0; alu_out = addr0;
    dmem.dreq_ready = !via_ready; dmem.dresp_valid = 1'b0;
    @(negedge clk);
    checkOutput({tag, ".req0"}, {31'h0, dmem.dreq_valid}, 32'h1);
    checkOutput({tag, ".addr0"}, dmem.dreq_addr, addr0);
    @(posedge clk); #1;
    is_new = 1'b0; flush = 1'b1; dmem.dreq_ready = via_ready;
    @(negedge clk);
    if (via_ready) checkOutput({tag, ".req_held"}, {31'h0, dmem.dreq_valid}, 32'h1);
    @(posedge clk); #1;
    flush = 1'b0; is_new = 1'b1; alu_out = addr1; dmem.dreq_ready = 1'b1;
    @(negedge clk);
    checkOutput({tag, ".drain_stall"}, {31'h0, is_stall}, 32'h1);
    checkOutput({tag, ".drain_noreq"}, {31'h0, dmem.dreq_valid}, 32'h0);
    @(posedge clk); #1;
    is_new = 1'b0; dmem.dresp_valid = 1'b1; dmem.dresp_rdata = 32'h1111_1111;
    @(negedge clk);
    checkOutput({tag, ".drop_stall"}, {31'h0, is_stall}, 32'h1);
    checkOutput({tag, ".drop_noreq"}, {31'h0, dmem.dreq_valid}, 32'h0);
    @(posedge clk); #1;
    dmem.dresp_valid = 1'b0;
    @(negedge clk);
    checkOutput({tag, ".req1"}, {31'h0, dmem.dreq_valid}, 32'h1);
    checkOutput({tag, ".addr1"}, dmem.dreq_addr, addr1);
    @(posedge clk); #1;
    dmem.dreq_ready = 1'b0; dmem.dresp_valid = 1'b1; dmem.dresp_rdata = 32'h2222_2222;
    @(negedge clk);
    checkOutput({tag, ".resp_stall"}, {31'h0, is_stall}, 32'h0);
    checkOutput({tag, ".out"}, next_mem_out, 32'h2222_2222);
    @(posedge clk); #1;
    dmem.dresp_valid = 1'b0;
    @(negedge clk);
    checkOutput({tag, ".held_out"}, next_mem_out, 32'h2222_2222);
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //          sel   size  sgn  addr          rs2           rdata         rdy ren  out           addr          wen   mask   wdata
    vecs[0]  = '{2'd1, 2'd2, 1'b0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 1, 32'hDEAD_BEEF, 32'h0000_0100, 1'b0, 4'hF, 32'h0};
    vecs[1]  = '{2'd1, 2'd0, 1'b1, 32'h0000_0103, 32'h0,        32'h8011_2233, 0, 0, 32'hFFFF_FF80, 32'h0000_0100, 1'b0, 4'h8, 32'h0};
    vecs[2]  = '{2'd1, 2'd0, 1'b0, 32'h0000_0103, 32'h0,        32'h8011_2233, 0, 0, 32'h0000_0080, 32'h0000_0100, 1'b0, 4'h8, 32'h0};
    vecs[3]  = '{2'd1, 2'd1, 1'b1, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 1, 0, 32'hFFFF_8001, 32'h0000_0100, 1'b0, 4'hC, 32'h0};
    vecs[4]  = '{2'd1, 2'd1, 1'b0, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 0, 2, 32'h0000_8001, 32'h0000_0100, 1'b0, 4'hC, 32'h0};
    vecs[5]  = '{2'd1, 2'd1, 1'b1, 32'h0000_0100, 32'h0,        32'h1234_7FFF, 0, 0, 32'h0000_7FFF, 32'h0000_0100, 1'b0, 4'h3, 32'h0};
    vecs[6]  = '{2'd1, 2'd0, 1'b1, 32'h0000_0201, 32'h0,        32'h0000_7F00, 3, 0, 32'h0000_007F, 32'h0000_0200, 1'b0, 4'h2, 32'h0};
    vecs[7]  = '{2'd2, 2'd1, 1'b0, 32'h0000_0102, 32'h1234_ABCD, 32'h0,        0, 0, 32'h0,         32'h0000_0100, 1'b1, 4'hC, 32'hABCD_0000};
    vecs[8]  = '{2'd2, 2'd0, 1'b0, 32'h0000_0101, 32'h0000_00A5, 32'h0,        1, 1, 32'h0,         32'h0000_0100, 1'b1, 4'h2, 32'hA5A5_A500};
    vecs[9]  = '{2'd2, 2'd2, 1'b0, 32'h0000_010C, 32'hCAFE_F00D, 32'h0,        2, 0, 32'h0,         32'h0000_010C, 1'b1, 4'hF, 32'hCAFE_F00D};
    vecs[10] = '{2'd0, 2'd2, 1'b0, 32'h1234_5678, 32'h0,        32'h0,        0, 0, 32'h1234_5678, 32'h0,        1'b0, 4'h0, 32'h0};
    vecs[11] = '{2'd3, 2'd2, 1'b0, 32'h0000_ABCD, 32'h0,        32'h0,        0, 0, 32'h0000_ABCD, 32'h0,        1'b0, 4'h0, 32'h0};
    vecs[12] = '{2'd1, 2'd3, 1'b0, 32'h0000_00FC, 32'h0,        32'h55AA_55AA, 0, 0, 32'h55AA_55AA, 32'h0000_00FC, 1'b0, 4'hF, 32'h0};

    dmem.dreq_ready = 1'b0; dmem.dresp_valid = 1'b0; dmem.dresp_rdata = 32'h0;
    mem_sel = 2'd1; mem_size = 2'd2; is_new = 1'b1; alu_out = 32'h0000_0104; rs2_data = 32'hFFFF_FFFF;
    #3;
    checkOutput("reset.dreq_valid", {31'h0, dmem.dreq_valid}, 32'h0);
    checkOutput("reset.dreq_addr",  dmem.dreq_addr, 32'h0);
    checkOutput("reset.dreq_wmask", {28'h0, dmem.dreq_wmask}, 32'h0);
    checkOutput("reset.dreq_wdata", dmem.dreq_wdata, 32'h0);
    checkOutput("reset.out",        next_mem_out, 32'h0);
    checkOutput("reset.stall",      {31'h0, is_stall}, 32'h0);
    checkOutput("reset.misalign",   {31'h0, misalign}, 32'h0);
    #9 rst_n = 1'b1;
    is_new = 1'b0; mem_sel = 2'd0;

    for (int i = 0; i < 13; i++) applyStimulus(vecs[i], i);
    @(posedge clk); #1 valid = 1'b0;

    runFlushSeq(1'b0, 32'h0000_0200, 32'h0000_0300);
    runFlushSeq(1'b1, 32'h0000_0400, 32'h0000_0500);

    @(posedge clk); #1;
    valid = 1'b1; is_new = 1'b1; mem_sel = 2'd1; mem_size = 2'd2; mem_signed = 1'b0;
    alu_out = 32'h0000_0101; dmem.dreq_ready = 1'b1;
    @(negedge clk);
`ifdef MEMSTAGE_MISALIGN_TRAP_EN
    checkOutput("misal.flag",  {31'h0, misalign}, 32'h1);
    checkOutput("misal.noreq", {31'h0, dmem.dreq_valid}, 32'h0);
    checkOutput("misal.stall", {31'h0, is_stall}, 32'h0);
    checkOutput("misal.out",   next_mem_out, 32'h0000_0101);
`else
    checkOutput("align.flag",  {31'h0, misalign}, 32'h0);
    checkOutput("align.req",   {31'h0, dmem.dreq_valid}, 32'h1);
    checkOutput("align.addr",  dmem.dreq_addr, 32'h0000_0100);
    checkOutput("align.wmask", {28'h0, dmem.dreq_wmask}, 32'hF);
    @(posedge clk); #1;
    is_new = 1'b0; dmem.dreq_ready = 1'b0; dmem.dresp_valid = 1'b1; dmem.dresp_rdata = 32'h89AB_CDEF;
    @(negedge clk);
    checkOutput("align.out",   next_mem_out, 32'h89AB_CDEF);
    @(posedge clk); #1;
    dmem.dresp_valid = 1'b0;
    mem_sel = 2'd2; mem_size = 2'd1; alu_out = 32'h0000_0103; rs2_data = 32'h0000_BEEF; is_new = 1'b1;
    dmem.dreq_ready = 1'b1;
    @(negedge clk);
    checkOutput("align.sh_wmask", {28'h0, dmem.dreq_wmask}, 32'hC);
    checkOutput("align.sh_wdata", dmem.dreq_wdata, 32'hBEEF_0000);
    @(posedge clk); #1;
    is_new = 1'b0; dmem.dreq_ready = 1'b0; dmem.dresp_valid = 1'b1;
    @(negedge clk);
    checkOutput("align.sh_out", next_mem_out, 32'h0);
`endif
    @(posedge clk); #1;
    valid = 1'b0; dmem.dreq_ready = 1'b0; dmem.dresp_valid = 1'b0;
    @(negedge clk);
    checkOutput("idle.out", next_mem_out, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
